result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, giving clocks per digit scan slot (legal range 1..65535).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value  input  8  unsigned accumulator result from the upstream calculator stage.
REQ-005 SHALL have port seg  output  7  segment drive, active-high, bit0=a through bit6=g.
REQ-006 SHALL have port digit_sel  output  3  one-hot active-high digit enable: bit0=units, bit1=tens, bit2=hundreds.
REQ-007 SHALL have port bcd  output  12  last converted value as packed BCD {hundreds, tens, units}.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-009 SHALL hold a register last_value and use a two-state FSM: IDLE and CONVERT.
REQ-010 In IDLE, when value != last_value at a clock edge (E0), the block SHALL capture value into last_value and the shift register, and enter CONVERT.
REQ-011 In CONVERT, the block SHALL perform one double-dabble iteration per edge (E1..E8): add 3 to each BCD nibble >= 5, then shift left one bit, taking the next binary MSB.
REQ-012 At E8, bcd SHALL load the finished result and the FSM SHALL return to IDLE; bcd SHALL remain unchanged at all other edges.
REQ-013 busy SHALL equal (state == CONVERT), i.e. high for exactly 8 cycles per conversion.
REQ-014 Changes on value during CONVERT SHALL be ignored; on return to IDLE, the current value SHALL be compared against last_value, so the most recent value is always converted eventually.
REQ-015 bcd hundreds nibble SHALL never exceed 2; codes 10..15 are unreachable.
REQ-016 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, the digit index SHALL advance 0->1->2->0.
REQ-017 With SCAN_DIV=1, the digit index SHALL advance on every edge.
REQ-018 digit_sel SHALL be one-hot of the digit index; seg SHALL be the decode of the selected bcd nibble.
REQ-019 The seg codes SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; any other code SHALL give 0x00.
REQ-020 Scanning SHALL run continuously and independently of conversion; the displayed digits SHALL switch to new values only when bcd updates.

Reset
REQ-021 When reset is high at an edge: state=IDLE, last_value=0, bcd=0x000, prescaler=0, digit index=0.
REQ-022 Following REQ-021, busy=0, digit_sel=3'b001, and seg=0x3F.
REQ-023 Reset during CONVERT SHALL abort the conversion; no partial result SHALL reach bcd.
REQ-024 After reset with value=0, no conversion SHALL start.

Configuration
REQ-025 With macro RESULT_DISPLAY_BLANK_EN defined, leading-zero blanking SHALL apply: the hundreds digit shows seg=0x00 when it is 0.
REQ-026 With RESULT_DISPLAY_BLANK_EN defined, the tens digit shows seg=0x00 when both hundreds and tens are 0.
REQ-027 The units digit SHALL never be blanked, and digit_sel scanning SHALL be unaffected by blanking.
REQ-028 Without RESULT_DISPLAY_BLANK_EN, all three digits SHALL always be decoded, showing leading zeros.

Structure
REQ-029 Package result_display_pkg SHALL hold the FSM state type, the digit-count constant (3), and the seven-segment code constants.
REQ-030 The seven-segment decode SHALL be a sub-module, seg7_decoder: 4-bit BCD in, 7-bit seg out, combinational.

Verification
REQ-031 Reset, value=0 -> busy stays 0, bcd=0x000, digit_sel steps 001->010->100->001 every SCAN_DIV clocks, seg=0x3F in all slots (macro off).
REQ-032 value 0->255 -> busy high 8 cycles, bcd=0x255 at E8, slots show 0x6D/0x6D/0x5B.
REQ-033 value=123, changed to 7 at E3 -> bcd=0x123, then a second 8-cycle conversion, then bcd=0x007.
REQ-034 value=7 -> with macro: hundreds/tens seg=0x00, units=0x07; without macro: hundreds/tens=0x3F.
REQ-035 value=100 with macro -> tens shows 0x3F (not blanked), hundreds 0x06.
REQ-036 Reset asserted at E4 of a conversion for 200 -> busy=0, bcd=0x000 next cycle; after release, a fresh conversion gives bcd=0x200.

Source files
------------

// File: rtl/result_display_pkg.sv
// result_display_pkg
//   Shared types and constants for the result_display block:
//   FSM state encoding, digit count, shift-register geometry,
//   seven-segment codes (active-high, bit0=a .. bit6=g) and the
//   double-dabble iteration helper.
package result_display_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  localparam int DIGIT_COUNT = 3;
  localparam int VALUE_W     = 8;
  localparam int BCD_W       = 4 * DIGIT_COUNT;
  localparam int SHIFT_W     = BCD_W + VALUE_W;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One double-dabble iteration on {bcd[11:0], binary[7:0]}:
  // correct every BCD nibble >= 5 by +3, then shift left so the
  // next binary MSB enters the units nibble.
  function automatic logic [SHIFT_W-1:0] dd_step(input logic [SHIFT_W-1:0] sr);
    logic [SHIFT_W-1:0] t;
    t = sr;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (t[VALUE_W + 4*i +: 4] >= 4'd5) begin
        t[VALUE_W + 4*i +: 4] = t[VALUE_W + 4*i +: 4] + 4'd3;
      end else begin
        t[VALUE_W + 4*i +: 4] = t[VALUE_W + 4*i +: 4];
      end
    end
    return {t[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/result_display_seg7_decoder.sv
// seg7_decoder
//   Combinational BCD to seven-segment decode. Codes 10..15 give a
//   dark digit.
//   Ports:
//     bcd : in  4  BCD digit
//     seg : out 7  active-high segments, bit0=a .. bit6=g
module seg7_decoder
  import result_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit code lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// result_display
//   Converts an 8-bit unsigned result to packed BCD with a serial
//   double-dabble engine (one iteration per clock, 8 clocks) and
//   scans the three digits onto a multiplexed seven-segment display.
//   A conversion starts whenever value differs from the last value
//   captured; changes during a conversion are picked up afterwards.
//   Parameter:
//     SCAN_DIV  : clocks per digit scan slot (1..65535)
//   Ports:
//     clock     : in  1   clock, rising edge
//     reset     : in  1   synchronous, active-high reset
//     value     : in  8   unsigned value to display
//     seg       : out 7   active-high segments of the selected digit
//     digit_sel : out 3   one-hot digit enable {hundreds, tens, units}
//     bcd       : out 12  last converted value {hundreds, tens, units}
//     busy      : out 1   conversion in progress
//   Build option:
//     RESULT_DISPLAY_BLANK_EN : blank leading zeros of hundreds/tens.
module result_display
  import result_display_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [VALUE_W-1:0]  value,
  output logic [6:0]          seg,
  output logic [2:0]          digit_sel,
  output logic [BCD_W-1:0]    bcd,
  output logic                busy
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  state_t               state_r;
  state_t               state_s;
  logic                 start_s;
  logic                 finish_s;
  logic [VALUE_W-1:0]   last_value_r;
  logic [SHIFT_W-1:0]   shift_r;
  logic [SHIFT_W-1:0]   step_s;
  logic [2:0]           iter_r;
  logic [BCD_W-1:0]     bcd_r;
  logic [15:0]          presc_r;
  logic [1:0]           digit_idx_r;
  logic [3:0]           nibble_s;
  logic                 blank_s;
  logic [6:0]           dec_seg_s;

  assign step_s = dd_step(shift_r);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: start on a changed input, finish after iteration 8.
  always_comb begin
    state_s  = state_r;
    start_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (value != last_value_r) begin
          state_s = ST_CONVERT;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (iter_r == 3'd7) begin
          state_s  = ST_IDLE;
          finish_s = 1'b1;
        end else begin
          state_s = ST_CONVERT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Conversion datapath: capture, iterate, publish on the last step only
  // so an aborted conversion never leaks a partial result.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_value_r <= {VALUE_W{1'b0}};
      shift_r      <= {SHIFT_W{1'b0}};
      iter_r       <= 3'd0;
      bcd_r        <= {BCD_W{1'b0}};
    end else begin
      if (start_s) begin
        last_value_r <= value;
        shift_r      <= {{BCD_W{1'b0}}, value};
        iter_r       <= 3'd0;
      end else if (state_r == ST_CONVERT) begin
        shift_r <= step_s;
        iter_r  <= iter_r + 3'd1;
      end else begin
        shift_r <= shift_r;
        iter_r  <= iter_r;
      end
      if (finish_s) begin
        bcd_r <= step_s[SHIFT_W-1:VALUE_W];
      end else begin
        bcd_r <= bcd_r;
      end
    end
  end

  // Scan prescaler and digit index; free-running, independent of the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_r     <= 16'd0;
      digit_idx_r <= 2'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r     <= 16'd0;
      digit_idx_r <= (digit_idx_r == 2'd2) ? 2'd0 : digit_idx_r + 2'd1;
    end else begin
      presc_r     <= presc_r + 16'd1;
      digit_idx_r <= digit_idx_r;
    end
  end

  // Digit select, nibble mux and leading-zero blanking.
  always_comb begin
    digit_sel = 3'b001;
    nibble_s  = bcd_r[3:0];
    blank_s   = 1'b0;
    case (digit_idx_r)
      2'd0: begin
        digit_sel = 3'b001;
        nibble_s  = bcd_r[3:0];
      end
      2'd1: begin
        digit_sel = 3'b010;
        nibble_s  = bcd_r[7:4];
`ifdef RESULT_DISPLAY_BLANK_EN
        blank_s   = (bcd_r[11:4] == 8'd0);
`else
        blank_s   = 1'b0;
`endif
      end
      2'd2: begin
        digit_sel = 3'b100;
        nibble_s  = bcd_r[11:8];
`ifdef RESULT_DISPLAY_BLANK_EN
        blank_s   = (bcd_r[11:8] == 4'd0);
`else
        blank_s   = 1'b0;
`endif
      end
      default: begin
        digit_sel = 3'b001;
        nibble_s  = bcd_r[3:0];
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .bcd (nibble_s),
    .seg (dec_seg_s)
  );

  assign seg  = blank_s ? SEG_BLANK : dec_seg_s;
  assign bcd  = bcd_r;
  assign busy = (state_r == ST_CONVERT);

endmodule

// File: tb/tb_result_display.sv
// tb_result_display
//   Scoreboard bench for result_display: each driven value change pushes
//   the expected BCD result; a monitor pops and compares it whenever a
//   conversion completes. Scan slots are checked against a reference
//   scan counter and a seven-segment table.
module tb_result_display;

  localparam int SCAN_DIV = 4;

  logic        clock;
  logic        reset;
  logic [7:0]  value;
  logic [6:0]  seg;
  logic [2:0]  digit_sel;
  logic [11:0] bcd;
  logic        busy;

  int n_checks;
  int n_fail;
  int done_cnt;
  int busy_len;
  logic busy_prev;
  logic rst_q;
  logic [11:0] shown_bcd;
  logic [11:0] sb[$];
  logic [15:0] m_presc;
  logic [1:0]  m_idx;

  result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock     (clock),
    .reset     (reset),
    .value     (value),
    .seg       (seg),
    .digit_sel (digit_sel),
    .bcd       (bcd),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_slot(input logic [11:0] b, input int idx);
    logic [3:0] n;
    logic blank;
    blank = 1'b0;
    n = b[idx*4 +: 4];
`ifdef RESULT_DISPLAY_BLANK_EN
    if (idx == 2 && b[11:8] == 4'd0) blank = 1'b1;
    if (idx == 1 && b[11:4] == 8'd0) blank = 1'b1;
`endif
    return blank ? 7'h00 : seg_code(n);
  endfunction

  // Reference scan position: SCAN_DIV clocks per slot, three slots.
  always @(posedge clock) begin
    rst_q <= reset;
    if (reset) begin
      m_presc <= 16'd0;
      m_idx   <= 2'd0;
    end else if (m_presc == 16'(SCAN_DIV - 1)) begin
      m_presc <= 16'd0;
      m_idx   <= (m_idx == 2'd2) ? 2'd0 : m_idx + 2'd1;
    end else begin
      m_presc <= m_presc + 16'd1;
    end
  end

  // Conversion monitor: busy length, bcd held while busy, result on completion.
  initial begin
    busy_prev = 1'b0;
    busy_len  = 0;
    shown_bcd = 12'h000;
    forever begin
      @(negedge clock);
      if (rst_q === 1'b1) begin
        shown_bcd = 12'h000;
        busy_len  = 0;
        busy_prev = 1'b0;
      end else if (busy === 1'b1) begin
        busy_len++;
        check("bcd_hold", 32'(bcd), 32'(shown_bcd));
        busy_prev = 1'b1;
      end else begin
        if (busy_prev) begin
          check("busy_len", busy_len, 8);
          check("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            shown_bcd = sb.pop_front();
            check("bcd_result", 32'(bcd), 32'(shown_bcd));
          end
          done_cnt++;
        end
        busy_len  = 0;
        busy_prev = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input int v);
    value = 8'(v);
    sb.push_back(to_bcd(v));
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 60 && done_cnt < target; i++) tick(1);
    check("done_count", done_cnt, target);
  endtask

  task automatic check_slots(input logic [11:0] exp_bcd, input string tag);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    for (int k = 0; k < 3 * SCAN_DIV; k++) begin
      check("digit_sel", 32'(digit_sel), 32'(3'b001 << m_idx));
      check(tag, 32'(seg), 32'(exp_slot(exp_bcd, int'(m_idx))));
      tick(1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    reset    = 1'b1;
    value    = 8'd0;
    tick(2);
    reset = 1'b0;

    // Reset state and idle scanning with value 0.
    check("rst_busy", 32'(busy), 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_digit_sel", 32'(digit_sel), 32'(3'b001));
    check("rst_seg", 32'(seg), 32'(exp_slot(12'h000, 0)));
    for (int k = 0; k < 6 * SCAN_DIV; k++) begin
      check("idle_busy", 32'(busy), 0);
      check("idle_digit_sel", 32'(digit_sel), 32'(3'b001 << ((k / SCAN_DIV) % 3)));
      check("idle_seg", 32'(seg), 32'(exp_slot(12'h000, (k / SCAN_DIV) % 3)));
      tick(1);
    end
    check("idle_no_conv", done_cnt, 0);

    // 0 -> 255.
    drive(255);
    tick(1);
    check("busy_after_e0", 32'(busy), 1);
    wait_done(1);
    check_slots(12'h255, "seg_255");

    // 123, then 7 arriving mid-conversion.
    drive(123);
    tick(3);
    drive(7);
    wait_done(3);
    check_slots(12'h007, "seg_007");

    // 100: tens zero is not a leading zero.
    drive(100);
    wait_done(4);
    check_slots(12'h100, "seg_100");

    // 200 aborted by reset at E4, then reconverted.
    value = 8'd200;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("abort_busy", 32'(busy), 0);
    check("abort_bcd", 32'(bcd), 0);
    check("abort_digit_sel", 32'(digit_sel), 32'(3'b001));
    reset = 1'b0;
    sb.push_back(to_bcd(200));
    wait_done(5);
    check_slots(12'h200, "seg_200");

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
